ascii_write_queue: RTL and testbench

Buffers character stores from the core's MMIO path (addresses at and above 0x00070000) and drains them into the text-mode character RAM inside the ASCII/VGA controller. The core issues single-cycle store pulses from its UPDATE state; the character RAM accepts writes only when the video side grants the port. This queue decouples the two sides so the core never stalls on video timing, and reports overflow back to the core/LEDs.

---
 rtl/ascii_write_queue.sv | 106 ++++++++++
 tb/tb_ascii_write_queue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_write_queue.sv
// rtl/ascii_write_queue.sv - store queue from core MMIO into text-mode character RAM
// Optional drop statistics counter built only when ASCII_WQ_STATS_EN is defined.
module ascii_write_queue #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned CHARS  = 4800
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [31:0]                wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  input  logic                       ram_ready,
  output logic                       ram_we,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic [7:0]                 ram_data,
  output logic [15:0]                drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [7:0]        mem_data [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count_n;
  logic              in_range;
  logic              push;
  logic              pop;
  logic              drop;
  logic              unused_hi;

  // Only the ASCII code byte is stored; the upper store bits are ignored.
  assign unused_hi = ^wr_data[31:8];

  assign in_range = ({{(32-ADDR_W){1'b0}}, wr_addr} < CHARS);
  // full/empty are the registered flags, so a store arriving while full is
  // dropped even when a pop happens on the same edge.
  assign push     = wr_en && in_range && !full;
  assign drop     = wr_en && (!in_range || full);
  assign pop      = ram_ready && !empty;

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[tail] <= wr_addr;
      mem_data[tail] <= wr_data[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count    <= count_n;
      full     <= (count_n == CW'(DEPTH));
      empty    <= (count_n == '0);
      if (drop) overflow <= 1'b1;
      ram_we   <= pop;
      if (pop) begin
        ram_addr <= mem_addr[head];
        ram_data <= mem_data[head];
      end
    end
  end

`ifdef ASCII_WQ_STATS_EN
  logic [15:0] drops;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drops <= 16'd0;
    end else if (drop && drops != 16'hFFFF) begin
      drops <= drops + 16'd1;
    end
  end

  assign drop_count = drops;
`else
  assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_ascii_write_queue.sv
// tb/tb_ascii_write_queue.sv - scoreboard bench for ascii_write_queue
module tb_ascii_write_queue;

`ifdef ASCII_WQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [12:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        full, empty, overflow, ram_we;
  logic [3:0]  count;
  logic        ram_ready = 1'b0;
  logic [12:0] ram_addr;
  logic [7:0]  ram_data;
  logic [15:0] drop_count;

  int total = 0;
  int bad = 0;
  int exp_drops = 0;
  logic [20:0] sb[$];

  ascii_write_queue #(.DEPTH(8), .ADDR_W(13), .CHARS(4800)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .ram_ready(ram_ready), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_data(ram_data), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Every issued RAM write must match the oldest accepted store.
  always @(negedge clk) begin
    if (!rst && ram_we) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL ram_we_unexpected: ram_we=1 addr=%0d data=%02h, no entry pending", ram_addr, ram_data);
      end else begin
        logic [20:0] e;
        e = sb.pop_front();
        if ({ram_addr, ram_data} !== e) begin
          bad++;
          $display("FAIL ram_write: got addr=%0d data=%02h, want addr=%0d data=%02h",
                   ram_addr, ram_data, e[20:8], e[7:0]);
        end
      end
    end
  end

  task automatic store(input logic [12:0] a, input logic [7:0] d, input bit accept);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = {24'hABCDEF, d};
    if (accept) sb.push_back({a, d});
    else exp_drops++;
    @(posedge clk) #1;
    wr_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    ram_ready = 1'b1;
    n = 0;
    while (!(empty && !ram_we) && n < 50) begin
      @(posedge clk) #1;
      n++;
    end
    @(posedge clk) #1;
    total++;
    if (n >= 50 || sb.size() != 0) begin
      bad++;
      $display("FAIL drain: cycles=%0d pending=%0d empty=%0b, want drained", n, sb.size(), empty);
    end
  endtask

  task automatic check_drops(input string tag);
    total++;
    if (drop_count !== (STATS ? 16'(exp_drops) : 16'd0)) begin
      bad++;
      $display("FAIL %s drop_count: got %0d want %0d", tag, drop_count, STATS ? exp_drops : 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({full, empty, count, overflow, ram_we, ram_addr, ram_data, drop_count} !==
        {1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 13'd0, 8'd0, 16'd0}) begin
      bad++;
      $display("FAIL reset: full=%0b empty=%0b count=%0d ovf=%0b we=%0b addr=%0d data=%0h drops=%0d, want 0 1 0 0 0 0 0 0",
               full, empty, count, overflow, ram_we, ram_addr, ram_data, drop_count);
    end
    @(posedge clk) #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    ram_ready = 1'b1;
    store(13'd5, 8'h41, 1'b1);
    @(negedge clk);
    total++;
    if (count !== 4'd1 || ram_we !== 1'b0) begin
      bad++;
      $display("FAIL single_push: count=%0d ram_we=%0b, want 1 0", count, ram_we);
    end
    @(negedge clk);
    total++;
    if (ram_we !== 1'b1 || empty !== 1'b1 || count !== 4'd0) begin
      bad++;
      $display("FAIL single_issue: ram_we=%0b empty=%0b count=%0d, want 1 1 0", ram_we, empty, count);
    end
    @(negedge clk);
    total++;
    if (ram_we !== 1'b0 || ram_addr !== 13'd5 || ram_data !== 8'h41) begin
      bad++;
      $display("FAIL single_hold: ram_we=%0b addr=%0d data=%02h, want 0 5 41", ram_we, ram_addr, ram_data);
    end
    @(posedge clk) #1;
  endtask

  task automatic test_full_drop();
    ram_ready = 1'b0;
    for (int i = 0; i < 8; i++) store(13'(i), 8'(8'h30 + i), 1'b1);
    store(13'd8, 8'h99, 1'b0);
    @(negedge clk);
    total++;
    if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b1 || empty !== 1'b0) begin
      bad++;
      $display("FAIL full_drop: full=%0b count=%0d ovf=%0b empty=%0b, want 1 8 1 0", full, count, overflow, empty);
    end
    check_drops("full_drop");
  endtask

  task automatic test_pop_while_full();
    @(posedge clk) #1;
    ram_ready = 1'b1;
    store(13'd9, 8'h77, 1'b0);
    ram_ready = 1'b0;
    @(negedge clk);
    total++;
    if (count !== 4'd7 || full !== 1'b0 || ram_we !== 1'b1) begin
      bad++;
      $display("FAIL pop_while_full: count=%0d full=%0b ram_we=%0b, want 7 0 1", count, full, ram_we);
    end
    check_drops("pop_while_full");
    @(posedge clk) #1;
    drain();
  endtask

  task automatic test_range();
    ram_ready = 1'b0;
    store(13'd4800, 8'h11, 1'b0);
    @(negedge clk);
    total++;
    if (count !== 4'd0 || empty !== 1'b1 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL range_4800: count=%0d empty=%0b ovf=%0b, want 0 1 1", count, empty, overflow);
    end
    check_drops("range_4800");
    @(posedge clk) #1;
    store(13'd4799, 8'h22, 1'b1);
    @(negedge clk);
    total++;
    if (count !== 4'd1) begin
      bad++;
      $display("FAIL range_4799: count=%0d, want 1", count);
    end
    @(posedge clk) #1;
    drain();
  endtask

  task automatic test_back_to_back();
    ram_ready = 1'b0;
    for (int i = 0; i < 4; i++) store(13'(200 + i), 8'($urandom_range(0, 255)), 1'b1);
    ram_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      store(13'(100 + 37 * i), 8'($urandom_range(0, 255)), 1'b1);
      total++;
      if (count !== 4'd4) begin
        bad++;
        $display("FAIL back_to_back_count step=%0d: count=%0d, want 4", i, count);
      end
    end
    drain();
  endtask

  task automatic test_reset_mid_drain();
    ram_ready = 1'b0;
    for (int i = 0; i < 5; i++) store(13'(300 + i), 8'(i), 1'b1);
    total++;
    if (count !== 4'd5) begin
      bad++;
      $display("FAIL mid_drain_fill: count=%0d, want 5", count);
    end
    ram_ready = 1'b1;
    rst = 1'b1;
    sb.delete();
    exp_drops = 0;
    #1;
    total++;
    if ({full, empty, count, overflow, ram_we, ram_addr, ram_data, drop_count} !==
        {1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 13'd0, 8'd0, 16'd0}) begin
      bad++;
      $display("FAIL mid_drain_reset: full=%0b empty=%0b count=%0d ovf=%0b we=%0b addr=%0d data=%0h drops=%0d",
               full, empty, count, overflow, ram_we, ram_addr, ram_data, drop_count);
    end
    @(posedge clk) #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (ram_we !== 1'b0 || count !== 4'd0) begin
        bad++;
        $display("FAIL post_reset_idle cycle=%0d: ram_we=%0b count=%0d, want 0 0", i, ram_we, count);
      end
    end
    ram_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_drop();
    test_pop_while_full();
    test_range();
    test_back_to_back();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
